// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcode encoding, strobe bit
// positions, FSM state type and the opcode-to-strobe decoder.
package alu_pkg;

    localparam int NUM_ALU_OPS = 13;

    // 4-bit opcode encoding; 13..15 are illegal
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHRA = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_NEG  = 4'd11;
    localparam logic [3:0] OP_NOT  = 4'd12;

    // Bit positions inside the one-hot alu_sel vector
    localparam int SEL_ADD  = 0;
    localparam int SEL_SUB  = 1;
    localparam int SEL_AND  = 2;
    localparam int SEL_OR   = 3;
    localparam int SEL_SHR  = 4;
    localparam int SEL_SHRA = 5;
    localparam int SEL_SHL  = 6;
    localparam int SEL_ROR  = 7;
    localparam int SEL_ROL  = 8;
    localparam int SEL_MUL  = 9;
    localparam int SEL_DIV  = 10;
    localparam int SEL_NEG  = 11;
    localparam int SEL_NOT  = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Opcode to one-hot strobe; illegal opcodes give all zeros
    function automatic logic [NUM_ALU_OPS-1:0] op_to_onehot(input logic [3:0] op);
        logic [NUM_ALU_OPS-1:0] v;
        v = {NUM_ALU_OPS{1'b0}};
        if (op <= OP_NOT) begin
            v[op] = 1'b1;
        end else begin
            v = {NUM_ALU_OPS{1'b0}};
        end
        return v;
    endfunction

    // Only the double-word ops produce a meaningful high result word
    function automatic logic op_has_hi(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_cycle_counter.sv
// Loadable down-counter that saturates at zero and flags when it is there.
module alu_cycle_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Count register: load has priority over decrement, never wraps below zero
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer in front of the shared combinational ALU: accepts one request,
// holds the one-hot strobe for a per-opcode number of cycles, captures the
// result into the Z pair and offers it on a valid/ready response port.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES   = 4,
    parameter int DIV_CYCLES   = 8,
    parameter int BASIC_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_op,
    input  logic [31:0]            req_rb,
    input  logic [31:0]            req_ry,
    output logic [31:0]            alu_rb,
    output logic [31:0]            alu_ry,
    output logic [NUM_ALU_OPS-1:0] alu_sel,
    input  logic [31:0]            alu_lo,
    input  logic [31:0]            alu_hi,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_lo,
    output logic [31:0]            rsp_hi,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam int MAX_MD  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int MAX_CYC = (MAX_MD > BASIC_CYCLES) ? MAX_MD : BASIC_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    // Counter preload is N-1: the strobe rises on the accept edge and the
    // capture happens on the edge where the counter is already zero.
    localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] BASIC_LOAD = CNT_W'(BASIC_CYCLES - 1);

    seq_state_e             state_r;
    seq_state_e             state_next_s;
    logic                   accept_s;
    logic                   err_accept_s;
    logic                   capture_s;
    logic                   cnt_load_s;
    logic                   cnt_dec_s;
    logic                   op_illegal_s;
    logic                   div_zero_s;
    logic [CNT_W-1:0]       cnt_load_val_s;
    logic                   cnt_zero_s;

    logic [3:0]             op_r;
    logic [31:0]            rb_r;
    logic [31:0]            ry_r;
    logic [NUM_ALU_OPS-1:0] alu_sel_r;
    logic [31:0]            lo_r;
    logic [31:0]            hi_r;
    logic                   err_r;
    logic                   rsp_valid_r;
    logic                   req_ready_r;
    logic                   busy_r;

    alu_cycle_counter #(
        .WIDTH(CNT_W)
    ) u_counter (
        .clk      (clk),
        .clr      (clr),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .dec      (cnt_dec_s),
        .zero     (cnt_zero_s)
    );

    // Next-state and control decode for the IDLE/EXEC/DONE sequencer
    always_comb begin
        state_next_s   = state_r;
        accept_s       = 1'b0;
        err_accept_s   = 1'b0;
        capture_s      = 1'b0;
        cnt_load_s     = 1'b0;
        cnt_dec_s      = 1'b0;
        op_illegal_s   = (req_op > OP_NOT);
        div_zero_s     = (req_op == OP_DIV) && (req_ry == 32'd0);

        case (req_op)
            OP_MUL:  cnt_load_val_s = MUL_LOAD;
            OP_DIV:  cnt_load_val_s = DIV_LOAD;
            default: cnt_load_val_s = BASIC_LOAD;
        endcase

        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (op_illegal_s || div_zero_s) begin
                        // Error cases never strobe the ALU
                        err_accept_s = 1'b1;
                        state_next_s = ST_DONE;
                    end else begin
                        cnt_load_s   = 1'b1;
                        state_next_s = ST_EXEC;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_zero_s) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    cnt_dec_s    = 1'b1;
                    state_next_s = ST_EXEC;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered handshake/status flags decoded from next state
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            rsp_valid_r <= (state_next_s == ST_DONE);
            req_ready_r <= (state_next_s == ST_IDLE);
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    // Operand latch, glitch-free strobe register and Z result capture
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            op_r      <= 4'd0;
            rb_r      <= 32'd0;
            ry_r      <= 32'd0;
            alu_sel_r <= {NUM_ALU_OPS{1'b0}};
            lo_r      <= 32'd0;
            hi_r      <= 32'd0;
            err_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                op_r <= req_op;
                rb_r <= req_rb;
                ry_r <= req_ry;
            end
            if (accept_s && err_accept_s) begin
                // DIV by zero reports remainder = dividend; illegal ops report zeros
                lo_r  <= 32'd0;
                hi_r  <= div_zero_s ? req_rb : 32'd0;
                err_r <= 1'b1;
            end else if (accept_s) begin
                alu_sel_r <= op_to_onehot(req_op);
                err_r     <= 1'b0;
            end else if (capture_s) begin
                alu_sel_r <= {NUM_ALU_OPS{1'b0}};
                lo_r      <= alu_lo;
                hi_r      <= op_has_hi(op_r) ? alu_hi : 32'd0;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign alu_rb    = rb_r;
    assign alu_ry    = ry_r;
    assign alu_sel   = alu_sel_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_lo    = lo_r;
    assign rsp_hi    = hi_r;
    assign rsp_err   = err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU in the loop and a
// scoreboard queue of expected responses built from the request stimulus.
module tb_alu_sequencer;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_rb;
    logic [31:0] req_ry;
    logic [31:0] alu_rb;
    logic [31:0] alu_ry;
    logic [12:0] alu_sel;
    logic [31:0] alu_lo;
    logic [31:0] alu_hi;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_err;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_sequencer #(
        .MUL_CYCLES(4), .DIV_CYCLES(8), .BASIC_CYCLES(1)
    ) dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rb(req_rb), .req_ry(req_ry),
        .alu_rb(alu_rb), .alu_ry(alu_ry), .alu_sel(alu_sel),
        .alu_lo(alu_lo), .alu_hi(alu_hi),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_err(rsp_err), .busy(busy)
    );

    // Reference result of one operation as seen by the consumer
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] rb, input logic [31:0] ry);
        exp_t        e;
        logic [63:0] p;
        logic [63:0] dbl;
        e   = '{lo: 32'd0, hi: 32'd0, err: 1'b0};
        dbl = {rb, rb};
        p   = 64'd0;
        case (op)
            OP_ADD:  e.lo = rb + ry;
            OP_SUB:  e.lo = rb - ry;
            OP_AND:  e.lo = rb & ry;
            OP_OR:   e.lo = rb | ry;
            OP_SHR:  e.lo = rb >> ry[4:0];
            OP_SHRA: e.lo = $unsigned($signed(rb) >>> ry[4:0]);
            OP_SHL:  e.lo = rb << ry[4:0];
            OP_ROR:  begin p = dbl >> ry[4:0]; e.lo = p[31:0]; end
            OP_ROL:  begin p = dbl << ry[4:0]; e.lo = p[63:32]; end
            OP_MUL:  begin p = {32'd0, rb} * {32'd0, ry}; e.lo = p[31:0]; e.hi = p[63:32]; end
            OP_DIV:  begin
                if (ry == 32'd0) begin e.err = 1'b1; e.hi = rb; end
                else begin e.lo = rb / ry; e.hi = rb % ry; end
            end
            OP_NEG:  e.lo = 32'd0 - rb;
            OP_NOT:  e.lo = ~rb;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Behavioural ALU: garbage when idle, garbage high word for single-word ops
    always_comb begin
        logic [3:0] op;
        exp_t       r;
        op = 4'd15;
        for (int i = 0; i < 13; i++) begin
            if (alu_sel[i]) op = 4'(i);
        end
        r = model(op, alu_rb, alu_ry);
        if (alu_sel == 13'd0) begin
            alu_lo = 32'hDEAD_BEEF;
            alu_hi = 32'hDEAD_BEEF;
        end else begin
            alu_lo = r.lo;
            alu_hi = ((op == OP_MUL) || (op == OP_DIV)) ? r.hi : 32'hA5A5_A5A5;
        end
    end

    function automatic int exp_cycles(input logic [3:0] op, input logic [31:0] ry);
        if (op > OP_NOT) return 0;
        if (op == OP_MUL) return 4;
        if (op == OP_DIV) return (ry == 32'd0) ? 0 : 8;
        return 1;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] rb, input logic [31:0] ry, input bit push);
        int w;
        w = 0;
        while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: req_ready=%0b required 1", req_ready);
        end
        req_valid = 1'b1; req_op = op; req_rb = rb; req_ry = ry;
        if (push) sb_q.push_back(model(op, rb, ry));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; measures strobe width and latency in edges
    task automatic run_to_rsp(input string name, input int exp_n, input logic [12:0] exp_sel);
        int strobe, lat;
        bit sel_bad;
        strobe = 0; lat = 0; sel_bad = 1'b0;
        while (!rsp_valid && lat < 50) begin
            if (alu_sel != 13'd0) begin
                strobe++;
                if (alu_sel !== exp_sel) sel_bad = 1'b1;
            end
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || lat != exp_n) begin
            errors++;
            $display("FAIL %s_latency: edges=%0d valid=%0b required %0d", name, lat, rsp_valid, exp_n);
        end
        checks++;
        if (strobe != exp_n) begin
            errors++;
            $display("FAIL %s_strobe: cycles=%0d required %0d", name, strobe, exp_n);
        end
        checks++;
        if (sel_bad) begin
            errors++;
            $display("FAIL %s_sel: strobe pattern not 0x%03h", name, exp_sel);
        end
        checks++;
        if (alu_sel !== 13'd0 || req_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: sel=%03h ready=%0b busy=%0b required 000/0/1", name, alu_sel, req_ready, busy);
        end
    endtask

    task automatic complete(input string name);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: response with empty scoreboard", name);
        end else begin
            e = sb_q.pop_front();
            if (rsp_lo !== e.lo || rsp_hi !== e.hi || rsp_err !== e.err) begin
                errors++;
                $display("FAIL %s_result: lo=%08h hi=%08h err=%0b required lo=%08h hi=%08h err=%0b",
                         name, rsp_lo, rsp_hi, rsp_err, e.lo, e.hi, e.err);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: valid=%0b ready=%0b required 0/1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] rb, input logic [31:0] ry);
        issue(op, rb, ry, 1'b1);
        run_to_rsp(name, exp_cycles(op, ry), op_to_onehot(op));
        complete(name);
    endtask

    task automatic test_reset();
        clr = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_rb = 32'd0; req_ry = 32'd0; rsp_ready = 1'b0;
        #12;
        checks++;
        if (alu_sel !== 13'd0 || alu_rb !== 32'd0 || alu_ry !== 32'd0 || rsp_lo !== 32'd0 ||
            rsp_hi !== 32'd0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: sel=%03h rb=%08h ry=%08h lo=%08h hi=%08h v=%0b e=%0b rdy=%0b busy=%0b required all 0 with rdy=1",
                     alu_sel, alu_rb, alu_ry, rsp_lo, rsp_hi, rsp_valid, rsp_err, req_ready, busy);
        end
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_basic();
        do_op("add", OP_ADD, 32'd5, 32'd7);
        do_op("sub", OP_SUB, 32'd3, 32'd10);
        do_op("shra", OP_SHRA, 32'h8000_0010, 32'd4);
        do_op("rol", OP_ROL, 32'h8000_0001, 32'd1);
    endtask

    task automatic test_mul();
        do_op("mul", OP_MUL, 32'h0001_0000, 32'h0001_0000);
    endtask

    task automatic test_div_stall();
        logic [31:0] lo0, hi0;
        logic        e0;
        issue(OP_DIV, 32'd17, 32'd5, 1'b1);
        run_to_rsp("div", 8, op_to_onehot(OP_DIV));
        lo0 = rsp_lo; hi0 = rsp_hi; e0 = rsp_err;
        req_valid = 1'b1; req_op = OP_ADD; req_rb = 32'd1; req_ry = 32'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_lo !== lo0 || rsp_hi !== hi0 ||
                rsp_err !== e0 || alu_sel !== 13'd0) begin
                errors++;
                $display("FAIL div_stall: v=%0b rdy=%0b lo=%08h hi=%08h sel=%03h required held", rsp_valid, req_ready, rsp_lo, rsp_hi, alu_sel);
            end
        end
        req_valid = 1'b0;
        complete("div");
    endtask

    task automatic test_errors();
        do_op("div0", OP_DIV, 32'd9, 32'd0);
        do_op("illegal", 4'd14, 32'h1234_5678, 32'd3);
        do_op("not", OP_NOT, 32'd0, 32'd0);
    endtask

    task automatic test_clr_abort();
        bit seen;
        issue(OP_MUL, 32'd6, 32'd7, 1'b0);
        @(posedge clk); #1;
        clr = 1'b1;
        #1;
        checks++;
        if (alu_sel !== 13'd0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_abort: sel=%03h v=%0b rdy=%0b busy=%0b required 000/0/1/0", alu_sel, rsp_valid, req_ready, busy);
        end
        @(posedge clk); #1;
        clr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL clr_no_rsp: rsp_valid seen after abort, required none");
        end
        do_op("or_after_clr", OP_OR, 32'hF0F0_0000, 32'h0000_0F0F);
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops[10];
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_SHR, OP_SHL, OP_ROR, OP_NEG, OP_MUL, OP_DIV, OP_NOT};
        for (int i = 0; i < 10; i++) begin
            do_op("b2b", ops[i], $urandom, $urandom_range(1, 32'hFFFF));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mul();
        test_div_stall();
        test_errors();
        test_clr_abort();
        test_back_to_back();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
